// File: rtl/sd_dma_sched_pkg.sv
// Shared types and constants for the SD-card sector DMA scheduler.
package sd_dma_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_INIT,
        ST_REQ,
        ST_RECV,
        ST_DRAIN,
        ST_ABORT
    } state_e;

    localparam logic [1:0] REG_DST    = 2'd0;
    localparam logic [1:0] REG_COUNT  = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int unsigned STAT_BUSY = 31;
    localparam int unsigned STAT_DONE = 30;
    localparam int unsigned STAT_ERR  = 29;

    localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/sd_dma_wbuf.sv
// Small packed-word FIFO between the SD byte packer and the dmem write port.
module sd_dma_wbuf #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] head,
    output logic        full,
    output logic        empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0] mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        push_ok;
    logic        pop_ok;

    // Extra pointer MSB distinguishes full from empty.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clr) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/sd_dma_sched.sv
// MMIO-programmed scheduler that reads SD sectors and streams them into dmem,
// sharing the dmem write port with the CPU (CPU always wins).
module sd_dma_sched
    import sd_dma_sched_pkg::*;
#(
    parameter logic [31:0] MMIO_BASE    = 32'h1001_0040,
    parameter int unsigned SECTOR_BYTES = 512,
    parameter int unsigned INIT_TIMEOUT = 25_000_000,
    parameter int unsigned BUF_DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [31:0] reg_rdata,
    input  logic        sd_initialized,
    output logic        sd_read_req,
    input  logic        sd_byte_valid,
    input  logic [7:0]  sd_byte,
    input  logic        sd_read_complete,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_sel,
    output logic        busy,
    output logic        done
);
    localparam int unsigned TMO_W = $clog2(INIT_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [31:0]       dst_q, dst_d;
    logic [31:0]       ptr_q, ptr_d;
    logic [15:0]       count_q, count_d;
    logic [15:0]       left_q, left_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0]       pack_q, pack_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              win_hit, reg_wr, go;
    logic [1:0]        reg_sel;
    logic              buf_push, buf_pop, buf_clr, buf_full, buf_empty;
    logic [31:0]       buf_head, buf_wdata;

    assign win_hit     = (cpu_addr[31:4] == MMIO_BASE[31:4]);
    assign reg_sel     = cpu_addr[3:2];
    assign reg_wr      = cpu_we && win_hit;
    assign go          = reg_wr && (reg_sel == REG_CTRL) && cpu_wdata[0];
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign sd_read_req = (state_q == ST_REQ);
    assign buf_wdata   = {sd_byte, pack_q};

    // DMA gets the write port only in cycles the CPU leaves the bus idle.
    assign buf_pop   = !buf_empty && !cpu_we && !cpu_re && (state_q != ST_ABORT) && !reset;
    assign mem_sel   = buf_pop;
    assign mem_we    = buf_pop ? 1'b1     : cpu_we;
    assign mem_addr  = buf_pop ? ptr_q    : cpu_addr;
    assign mem_wdata = buf_pop ? buf_head : cpu_wdata;

    always_comb begin
        reg_rdata = '0;
        if (win_hit) begin
            unique case (reg_sel)
                REG_DST:   reg_rdata = dst_q;
                REG_COUNT: reg_rdata = {16'd0, count_q};
                REG_CTRL:  reg_rdata = '0;
                default: begin
                    reg_rdata[STAT_BUSY] = busy;
                    reg_rdata[STAT_DONE] = done_q;
                    reg_rdata[STAT_ERR]  = err_q;
                    reg_rdata[15:0]      = left_q;
                end
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        dst_d      = dst_q;
        ptr_d      = ptr_q;
        count_d    = count_q;
        left_d     = left_q;
        byte_cnt_d = byte_cnt_q;
        pack_d     = pack_q;
        tmo_d      = tmo_q;
        done_d     = done_q;
        err_d      = err_q;
        buf_push   = 1'b0;
        buf_clr    = 1'b0;

        if (buf_pop) ptr_d = ptr_q + 32'd4;

        if (reg_wr && !busy) begin
            if (reg_sel == REG_DST)   dst_d   = {cpu_wdata[31:2], 2'b00};
            if (reg_sel == REG_COUNT) count_d = cpu_wdata[15:0];
        end

        unique case (state_q)
            ST_IDLE: begin
                if (go) begin
                    done_d = (count_q == 16'd0);
                    err_d  = 1'b0;
                    left_d = count_q;
                    ptr_d  = dst_q;
                    tmo_d  = '0;
                    if (count_q != 16'd0) state_d = ST_WAIT_INIT;
                end
            end
            ST_WAIT_INIT: begin
                if (sd_initialized) begin
                    state_d = ST_REQ;
                end else if (tmo_q == TMO_W'(INIT_TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_REQ: begin
                byte_cnt_d = '0;
                state_d    = ST_RECV;
            end
            ST_RECV: begin
                if (sd_byte_valid) begin
                    if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    unique case (byte_cnt_q[1:0])
                        2'd0: pack_d[7:0]   = sd_byte;
                        2'd1: pack_d[15:8]  = sd_byte;
                        2'd2: pack_d[23:16] = sd_byte;
                        default: begin
                            // A pop in the same cycle frees the slot this word needs.
                            if (buf_full && !buf_pop) begin
                                err_d   = 1'b1;
                                state_d = ST_ABORT;
                            end else begin
                                buf_push = 1'b1;
                            end
                        end
                    endcase
                end
                if (sd_read_complete && (state_d != ST_ABORT)) begin
                    if (byte_cnt_d == CNT_W'(SECTOR_BYTES)) begin
                        left_d  = left_q - 16'd1;
                        state_d = (left_q != 16'd1) ? ST_REQ : ST_DRAIN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_ABORT;
                    end
                end
            end
            ST_DRAIN: begin
                if (buf_empty) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_ABORT: begin
                buf_clr = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            dst_q      <= '0;
            ptr_q      <= '0;
            count_q    <= '0;
            left_q     <= '0;
            byte_cnt_q <= '0;
            pack_q     <= '0;
            tmo_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dst_q      <= dst_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            left_q     <= left_d;
            byte_cnt_q <= byte_cnt_d;
            pack_q     <= pack_d;
            tmo_q      <= tmo_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    sd_dma_wbuf #(
        .DEPTH (BUF_DEPTH)
    ) u_wbuf (
        .clk       (clk),
        .reset     (reset),
        .clr       (buf_clr),
        .push      (buf_push),
        .push_data (buf_wdata),
        .pop       (buf_pop),
        .head      (buf_head),
        .full      (buf_full),
        .empty     (buf_empty)
    );

endmodule

// File: tb/tb_sd_dma_sched.sv
// Directed bench for sd_dma_sched: SD byte-stream model plus dmem write scoreboard.
module tb_sd_dma_sched;

    localparam logic [31:0] A_DST  = 32'h1001_0040;
    localparam logic [31:0] A_CNT  = 32'h1001_0044;
    localparam logic [31:0] A_CTRL = 32'h1001_0048;
    localparam logic [31:0] A_STAT = 32'h1001_004C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cpu_addr = A_STAT;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_we = 1'b0;
    logic        cpu_re = 1'b0;
    logic [31:0] reg_rdata;
    logic        sd_initialized = 1'b1;
    logic        sd_read_req;
    logic        sd_byte_valid = 1'b0;
    logic [7:0]  sd_byte = '0;
    logic        sd_read_complete = 1'b0;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_we, mem_sel, busy, done;

    always #5 clk = ~clk;

    sd_dma_sched #(
        .INIT_TIMEOUT (50)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .cpu_addr         (cpu_addr),
        .cpu_wdata        (cpu_wdata),
        .cpu_we           (cpu_we),
        .cpu_re           (cpu_re),
        .reg_rdata        (reg_rdata),
        .sd_initialized   (sd_initialized),
        .sd_read_req      (sd_read_req),
        .sd_byte_valid    (sd_byte_valid),
        .sd_byte          (sd_byte),
        .sd_read_complete (sd_read_complete),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_we           (mem_we),
        .mem_sel          (mem_sel),
        .busy             (busy),
        .done             (done)
    );

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard: every DMA write must carry the packed pattern for its offset.
    int          wr_cnt, data_err, sel_viol, req_cyc, req_dbl;
    logic [31:0] base_addr, last_addr, first_data;
    logic        prev_req = 1'b0;

    always @(negedge clk) begin
        logic [31:0] k;
        logic [7:0]  b;
        #2;
        if (mem_sel && mem_we) begin
            k = (mem_addr - base_addr) >> 2;
            b = 8'(k << 2);
            if (mem_wdata !== {b + 8'd3, b + 8'd2, b + 8'd1, b}) data_err++;
            if (wr_cnt == 0) first_data = mem_wdata;
            wr_cnt++;
            last_addr = mem_addr;
        end
        if (mem_sel && (cpu_re || cpu_we)) sel_viol++;
        if (sd_read_req) begin
            req_cyc++;
            if (prev_req) req_dbl++;
        end
        prev_req = sd_read_req;
    end

    task automatic clr_mon(input logic [31:0] base);
        wr_cnt = 0; data_err = 0; sel_viol = 0; req_cyc = 0; req_dbl = 0;
        base_addr = base; last_addr = '0; first_data = '0;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1;
        @(negedge clk);
        cpu_we = 1'b0; cpu_addr = A_STAT;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        cpu_addr = a;
        #1 d = reg_rdata;
        cpu_addr = A_STAT;
    endtask

    // SD model: wait for a request, stream nbytes of i[7:0] with gaps, then complete.
    task automatic sd_sector(input int nbytes, input int gap, output logic [31:0] stat);
        int t = 0;
        while (sd_read_req !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("req_wait", 32'(sd_read_req), 32'd1);
        @(negedge clk);
        for (int i = 0; i < nbytes; i++) begin
            sd_byte_valid = 1'b1; sd_byte = 8'(i);
            @(negedge clk);
            sd_byte_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        sd_read_complete = 1'b1;
        @(negedge clk);
        sd_read_complete = 1'b0;
        stat = reg_rdata;
    endtask

    task automatic wait_idle(input int max);
        int t = 0;
        while (busy && t < max) begin
            @(negedge clk);
            t++;
        end
        chk("idle_wait", 32'(busy), 32'd0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] st, st1, st2;
        int w0, w1, w2;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        clr_mon(32'h0);
        peek(A_STAT, st);
        chk("rst_status", st, 32'h0);
        chk("rst_outs", {27'd0, busy, done, mem_sel, mem_we, sd_read_req}, 32'h0);
        peek(A_DST, st);
        chk("rst_dst", st, 32'h0);

        cpu_write(A_DST, 32'h0000_0103);
        peek(A_DST, st);
        chk("dst_align", st, 32'h0000_0100);
        cpu_write(A_CNT, 32'hABCD_0001);
        peek(A_CNT, st);
        chk("count_mask", st, 32'h0000_0001);

        // 1: single sector
        clr_mon(32'h100);
        cpu_write(A_CTRL, 32'h1);
        sd_sector(512, 1, st);
        wait_idle(100);
        chk("t1_wr_cnt", 32'(wr_cnt), 32'd128);
        chk("t1_first", first_data, 32'h0302_0100);
        chk("t1_last", last_addr, 32'h0000_02FC);
        chk("t1_data", 32'(data_err), 32'd0);
        peek(A_STAT, st);
        chk("t1_status", st, 32'h4000_0000);
        chk("t1_done", 32'(done), 32'd1);

        // 2: CPU loads stall the DMA for 10 cycles
        clr_mon(32'h100);
        cpu_write(A_CTRL, 32'h1);
        fork
            sd_sector(512, 1, st);
            begin
                repeat (100) @(negedge clk);
                cpu_re = 1'b1;
                repeat (10) @(negedge clk);
                cpu_re = 1'b0;
            end
        join
        wait_idle(100);
        chk("t2_wr_cnt", 32'(wr_cnt), 32'd128);
        chk("t2_data", 32'(data_err), 32'd0);
        chk("t2_sel", 32'(sel_viol), 32'd0);
        chk("t2_last", last_addr, 32'h0000_02FC);

        // 3: three sectors, destination wraps past 2^32; writes/go while busy ignored
        cpu_write(A_DST, 32'hFFFF_FC00);
        cpu_write(A_CNT, 32'd3);
        clr_mon(32'hFFFF_FC00);
        cpu_write(A_CTRL, 32'h1);
        fork
            begin
                sd_sector(512, 1, st);
                sd_sector(512, 1, st1);
                sd_sector(512, 1, st2);
            end
            begin
                repeat (50) @(negedge clk);
                cpu_write(A_DST, 32'h5555_0000);
                cpu_write(A_CNT, 32'd9);
                cpu_write(A_CTRL, 32'h1);
            end
        join
        chk("t3_left2", {16'd0, st[15:0]}, 32'd2);
        chk("t3_left1", {16'd0, st1[15:0]}, 32'd1);
        chk("t3_left0", {16'd0, st2[15:0]}, 32'd0);
        wait_idle(100);
        chk("t3_req", 32'(req_cyc), 32'd3);
        chk("t3_req_dbl", 32'(req_dbl), 32'd0);
        chk("t3_wr_cnt", 32'(wr_cnt), 32'd384);
        chk("t3_last", last_addr, 32'h0000_01FC);
        chk("t3_data", 32'(data_err), 32'd0);
        peek(A_DST, st);
        chk("t3_dst_kept", st, 32'hFFFF_FC00);
        peek(A_CNT, st);
        chk("t3_cnt_kept", st, 32'd3);

        // 4a: short sector
        cpu_write(A_DST, 32'h200);
        cpu_write(A_CNT, 32'd1);
        clr_mon(32'h200);
        cpu_write(A_CTRL, 32'h1);
        sd_sector(100, 1, st);
        chk("t4_err_bit", {31'd0, st[29]}, 32'd1);
        wait_idle(20);
        w0 = wr_cnt;
        chk("t4_wr_cnt", 32'(w0), 32'd25);
        repeat (20) @(negedge clk);
        chk("t4_no_wr", 32'(wr_cnt), 32'(w0));
        peek(A_STAT, st);
        chk("t4_status", st, 32'h2000_0001);

        // 4b: CPU hogs the bus until the buffer overflows
        clr_mon(32'h200);
        cpu_write(A_CTRL, 32'h1);
        w0 = 0; w1 = 0; w2 = 0;
        fork
            sd_sector(512, 1, st);
            begin
                repeat (30) @(negedge clk);
                cpu_re = 1'b1;
                w0 = wr_cnt;
                repeat (60) @(negedge clk);
                w1 = wr_cnt;
                cpu_re = 1'b0;
                repeat (5) @(negedge clk);
                w2 = wr_cnt;
            end
        join
        chk("t4b_pre_wr", 32'(w0 > 0), 32'd1);
        chk("t4b_hold", 32'(w1), 32'(w0));
        chk("t4b_flush", 32'(w2), 32'(w1));
        chk("t4b_after", 32'(wr_cnt), 32'(w1));
        chk("t4b_data", 32'(data_err), 32'd0);
        peek(A_STAT, st);
        chk("t4b_status", st, 32'h2000_0001);

        // 5a: init timeout
        sd_initialized = 1'b0;
        clr_mon(32'h0);
        cpu_write(A_CTRL, 32'h1);
        repeat (50) @(negedge clk);
        peek(A_STAT, st);
        chk("t5_wait50", st, 32'h8000_0001);
        @(negedge clk);
        peek(A_STAT, st);
        chk("t5_tmo51", st, 32'h2000_0001);
        chk("t5_no_req", 32'(req_cyc), 32'd0);
        sd_initialized = 1'b1;

        // 5b: zero count
        cpu_write(A_CNT, 32'd0);
        cpu_write(A_CTRL, 32'h1);
        peek(A_STAT, st);
        chk("t5_zero", st, 32'h4000_0000);
        repeat (10) @(negedge clk);
        chk("t5_zero_req", 32'(req_cyc), 32'd0);

        // 6: reset mid-transfer, then a clean restart
        cpu_write(A_DST, 32'h100);
        cpu_write(A_CNT, 32'd1);
        clr_mon(32'h100);
        cpu_write(A_CTRL, 32'h1);
        w0 = 0;
        fork
            sd_sector(512, 1, st);
            begin
                repeat (100) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                w0 = wr_cnt;
                peek(A_STAT, st1);
                chk("t6_status", st1, 32'h0);
                chk("t6_outs", {30'd0, mem_sel, sd_read_req}, 32'h0);
                peek(A_DST, st1);
                chk("t6_dst", st1, 32'h0);
            end
        join
        chk("t6_no_wr", 32'(wr_cnt), 32'(w0));
        cpu_write(A_DST, 32'h100);
        cpu_write(A_CNT, 32'd1);
        clr_mon(32'h100);
        cpu_write(A_CTRL, 32'h1);
        sd_sector(512, 1, st);
        wait_idle(100);
        chk("t6_wr_cnt", 32'(wr_cnt), 32'd128);
        chk("t6_first", first_data, 32'h0302_0100);
        chk("t6_data", 32'(data_err), 32'd0);
        peek(A_STAT, st);
        chk("t6_final", st, 32'h4000_0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
